// File: rtl/quadrature_generator.sv
// quadrature_generator: commanded quadrature edge generator with position tracking; QUAD_GEN_BOUNCE_EN adds contact-bounce emulation
module quadrature_generator #(
    parameter int PERIOD = 10,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_steps,
    input  logic             abort,
    output logic             quadA,
    output logic             quadB,
    output logic [WIDTH-1:0] position,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam logic [15:0] TIMER_LOAD = 16'(PERIOD - 1);
    state_t           state;
    logic [1:0]       p;
    logic [1:0]       p_next;
    logic [15:0]      timer;
    logic [WIDTH-1:0] remaining;
    logic             dir;
    logic             accept;
    logic             fire;
    function automatic logic [1:0] ab(input logic [1:0] q);
        return {q[1] ^ q[0], q[1]};
    endfunction
    if (PERIOD < 1 || PERIOD > 65535) begin : g_period_range
        $error("quadrature_generator: PERIOD must be 1..65535");
    end
    // handshake, edge-due and next-phase decode
    always_comb begin
        accept = state == S_IDLE && cmd_ready && cmd_valid;
        fire   = state == S_RUN && timer == '0 && !abort;
        p_next = dir ? p + 2'd1 : p - 2'd1;
    end
    // command FSM: edge timing, phase/position tracking and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir       <= 1'b0;
            remaining <= '0;
            timer     <= '0;
            p         <= '0;
            position  <= '0;
        end else begin
            cmd_ready <= state == S_IDLE && !accept;
            busy      <= !(state == S_IDLE && !accept);
            done      <= state == S_DONE;
            case (state)
                S_IDLE: if (accept) begin
                    dir       <= cmd_dir;
                    remaining <= cmd_steps;
                    timer     <= TIMER_LOAD;
                    state     <= cmd_steps == '0 ? S_DONE : S_RUN;
                end
                S_RUN: if (abort) begin
                    state <= S_IDLE;
                end else if (timer == '0) begin
                    p         <= p_next;
                    position  <= dir ? position + 1'b1 : position - 1'b1;
                    remaining <= remaining - 1'b1;
                    timer     <= TIMER_LOAD;
                    if (remaining == WIDTH'(1)) state <= S_DONE;
                end else begin
                    timer <= timer - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`ifdef QUAD_GEN_BOUNCE_EN
    logic [1:0] bnc;
    logic [1:0] p_back;
    assign p_back = dir ? p - 2'd1 : p + 2'd1;
    if (PERIOD < 3) begin : g_bounce_period
        $error("quadrature_generator: PERIOD must be >= 3 with QUAD_GEN_BOUNCE_EN");
    end
    // line drivers: each edge flips, reverts once, then settles on the new phase
    always_ff @(posedge clk) begin
        if (!reset) begin
            {quadA, quadB} <= 2'b00;
            bnc            <= 2'd0;
        end else if (state == S_RUN && abort) begin
            {quadA, quadB} <= ab(p);
            bnc            <= 2'd0;
        end else if (fire) begin
            {quadA, quadB} <= ab(p_next);
            bnc            <= 2'd2;
        end else if (bnc == 2'd2) begin
            {quadA, quadB} <= ab(p_back);
            bnc            <= 2'd1;
        end else if (bnc == 2'd1) begin
            {quadA, quadB} <= ab(p);
            bnc            <= 2'd0;
        end
    end
`else
    // line drivers: one clean change per edge, same clock as the phase update
    always_ff @(posedge clk) begin
        if (!reset) {quadA, quadB} <= 2'b00;
        else if (fire) {quadA, quadB} <= ab(p_next);
    end
`endif
endmodule

// File: tb/tb_quadrature_generator.sv
// tb_quadrature_generator: table-driven and randomized check of quadrature_generator against a timing model
module tb_quadrature_generator;
    localparam int P = 10;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_dir = 1'b0;
    logic [W-1:0] cmd_steps = '0;
    logic         abort = 1'b0;
    logic         quad_a;
    logic         quad_b;
    logic [W-1:0] position;
    logic         busy;
    logic         done;
    int n_cmp = 0;
    int n_bad = 0;
    int m_pos = 0;
    int m_ph  = 0;
    logic [1:0] lut [4];
    typedef struct {
        logic       dir;
        int         steps;
        int         abort_at;
        bit         hold;
        int         exp_edges;
        int         exp_pos;
        logic [1:0] exp_ab;
        int         exp_done;
    } vec_t;
    vec_t tbl [10];

    quadrature_generator #(.PERIOD(P), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort),
        .quadA(quad_a), .quadB(quad_b), .position(position), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wrap(input int v, input int m);
        return ((v % m) + m) % m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_ab"}, {quad_a, quad_b}, 2'b00);
        chk({tag, "_pos"}, position, 0);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Issue one command and check every cycle until cmd_ready returns.
    task automatic run_cmd(input logic dir, input int steps, input int abort_at, input bit hold,
                           output int edges, output int dones);
        int w;
        int n;
        int cap;
        int end_k;
        bit active;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        chk("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = W'(steps);
        tick();
        if (hold) begin
            cmd_dir   = ~dir;
            cmd_steps = W'(steps + 3);
        end else begin
            cmd_valid = 1'b0;
        end
        active = abort_at >= 1 && abort_at <= steps * P;
        cap    = active ? (abort_at - 1) / P : steps;
        end_k  = active ? abort_at + 1 : steps * P + 2;
        dones  = 0;
        n      = 0;
        for (int k = 1; k <= end_k; k++) begin
            abort = (k == abort_at);
            tick();
            n = k / P;
            if (n > cap) n = cap;
            chk("ab", {quad_a, quad_b}, lut[wrap(m_ph + (dir ? n : -n), 4)]);
            chk("pos", position, wrap(m_pos + (dir ? n : -n), 256));
            chk("done", done, !active && k == steps * P + 1);
            chk("ready", cmd_ready, k >= end_k);
            chk("busy", busy, k < end_k);
            dones += int'(done);
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        edges     = n;
        m_pos     = wrap(m_pos + (dir ? n : -n), 256);
        m_ph      = wrap(m_ph + (dir ? n : -n), 4);
    endtask

    initial begin
        int edges;
        int dones;
        lut = '{2'b00, 2'b10, 2'b11, 2'b01};
        tbl = '{
            '{1'b1, 4, 0,  1'b0, 4, 4,   2'b00, 1},
            '{1'b0, 4, 0,  1'b0, 4, 0,   2'b00, 1},
            '{1'b0, 2, 0,  1'b0, 2, 254, 2'b11, 1},
            '{1'b1, 8, 25, 1'b0, 2, 0,   2'b00, 0},
            '{1'b1, 8, 30, 1'b0, 2, 2,   2'b11, 0},
            '{1'b1, 0, 0,  1'b0, 0, 2,   2'b11, 1},
            '{1'b0, 3, 0,  1'b1, 3, 255, 2'b01, 1},
            '{1'b1, 1, 10, 1'b0, 0, 255, 2'b01, 0},
            '{1'b1, 1, 11, 1'b0, 1, 0,   2'b00, 1},
            '{1'b0, 1, 1,  1'b0, 0, 0,   2'b00, 0}
        };
        reset = 1'b0;
        tick();
        tick();
        check_idle_reset("reset");
        reset = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].dir, tbl[i].steps, tbl[i].abort_at, tbl[i].hold, edges, dones);
            chk("vec_edges", edges, tbl[i].exp_edges);
            chk("vec_pos", position, tbl[i].exp_pos);
            chk("vec_ab", {quad_a, quad_b}, tbl[i].exp_ab);
            chk("vec_dones", dones, tbl[i].exp_done);
        end
        // reset in the middle of a move discards the command and clears the lines
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd8;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        reset = 1'b0;
        tick();
        check_idle_reset("midreset");
        reset = 1'b1;
        m_pos = 0;
        m_ph  = 0;
        for (int k = 0; k < 12; k++) tick();
        check_idle_reset("postreset");
        for (int i = 0; i < 40; i++) begin
            logic d;
            int s;
            int a;
            bit h;
            d = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, 12));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, s * P + 1)) : 0;
            h = 1'($urandom_range(0, 1));
            run_cmd(d, s, a, h, edges, dones);
            chk("rnd_dones", dones, (a >= 1 && a <= s * P) ? 0 : 1);
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
